// File: rtl/piso_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : piso_pkg                                                  |
// | Purpose  : Shared types and constants for the parallel-in/serial-out |
// |            transmitter (state encoding, default word width).         |
// | Ports    : none (package)                                            |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
package piso_pkg;

  localparam int PISO_WIDTH_DEFAULT = 4;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } piso_state_e;

endpackage : piso_pkg
`default_nettype wire

// File: rtl/piso_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : piso_if                                                   |
// | Purpose  : Word handshake (in) and qualified serial stream (out) of  |
// |            the piso transmitter.                                     |
// | Ports    : in_valid/p_in/in_ready - parallel word handshake          |
// |            out_valid/s_out       - serial bit plus qualifier         |
// |            modport master : word source / serial sink side           |
// |            modport slave  : transmitter side                         |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
interface piso_if
  import piso_pkg::*;
#(
  parameter int WIDTH = PISO_WIDTH_DEFAULT
);

  logic             in_valid;
  logic [WIDTH-1:0] p_in;
  logic             in_ready;
  logic             out_valid;
  logic             s_out;

  modport master (
    output in_valid,
    output p_in,
    input  in_ready,
    input  out_valid,
    input  s_out
  );

  modport slave (
    input  in_valid,
    input  p_in,
    output in_ready,
    output out_valid,
    output s_out
  );

endinterface : piso_if
`default_nettype wire

// File: rtl/piso_hold_buf.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : piso_hold_buf                                             |
// | Purpose  : One-entry holding register that parks the next word      |
// |            while the current word is still shifting out.             |
// | Ports    : clk, rst_n      - clock, synchronous active-low reset     |
// |            i_load, i_data  - capture a word, mark entry full         |
// |            i_take          - entry consumed, mark empty              |
// |            o_hold_valid    - entry full                              |
// |            o_data          - stored word                             |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module piso_hold_buf
  import piso_pkg::*;
#(
  parameter int WIDTH = PISO_WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_take,
  output logic             o_hold_valid,
  output logic [WIDTH-1:0] o_data
);

  logic             r_valid;
  logic [WIDTH-1:0] r_data;

  // Load and take are never asserted together by the top (load needs an
  // empty entry, take needs a full one); load wins if they ever coincide.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_data  <= '0;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_data  <= i_data;
    end else if (i_take) begin
      r_valid <= 1'b0;
    end
  end

  assign o_hold_valid = r_valid;
  assign o_data       = r_data;

endmodule : piso_hold_buf
`default_nettype wire

// File: rtl/piso.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : piso                                                      |
// | Purpose  : Parallel-in/serial-out transmitter. Accepts WIDTH-bit     |
// |            words on a valid/ready handshake and sends them MSB       |
// |            first, one bit per clock, qualified by out_valid. A       |
// |            one-word holding register allows gap-free back-to-back    |
// |            words.                                                    |
// | Ports    : clk   - clock, rising edge                                |
// |            rst_n - synchronous active-low reset                      |
// |            bus   - piso_if.slave (in_valid, p_in, in_ready,          |
// |                    out_valid, s_out)                                 |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module piso
  import piso_pkg::*;
#(
  parameter int WIDTH = PISO_WIDTH_DEFAULT
) (
  input  logic    clk,
  input  logic    rst_n,
  piso_if.slave   bus
);

  localparam int            CW         = $clog2(WIDTH);
  localparam logic [CW-1:0] c_LAST_CNT = CW'(WIDTH - 1);

  if (WIDTH < 2 || WIDTH > 32) begin : g_width_check
    $error("piso: WIDTH must be in 2..32");
  end

  piso_state_e      r_state;
  logic [WIDTH-1:0] r_sreg;
  logic [CW-1:0]    r_bit_cnt;
  logic             r_out_valid;

  logic             w_hold_valid;
  logic [WIDTH-1:0] w_hold_data;
  logic             w_accept;
  logic             w_last_bit;
  logic             w_hold_load;
  logic             w_hold_take;

  // in_ready depends only on the holding-register flag, so there is no
  // combinational path from in_valid back to in_ready.
  assign w_accept    = bus.in_valid && !w_hold_valid;
  assign w_last_bit  = (r_state == SHIFT) && (r_bit_cnt == c_LAST_CNT);
  // Mid-word accepts are parked; on the last bit an accept (with an empty
  // buffer) goes straight into the shift register instead.
  assign w_hold_load = w_accept && (r_state == SHIFT) && !w_last_bit;
  assign w_hold_take = w_last_bit && w_hold_valid;

  piso_hold_buf #(
    .WIDTH (WIDTH)
  ) u_hold_buf (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_load       (w_hold_load),
    .i_data       (bus.p_in),
    .i_take       (w_hold_take),
    .o_hold_valid (w_hold_valid),
    .o_data       (w_hold_data)
  );

  // The shift register is cleared whenever the FSM returns to IDLE, so its
  // MSB is already 0 outside SHIFT and can drive s_out directly.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_sreg      <= '0;
      r_bit_cnt   <= '0;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_sreg      <= bus.p_in;
            r_bit_cnt   <= '0;
            r_state     <= SHIFT;
            r_out_valid <= 1'b1;
          end
        end
        SHIFT: begin
          if (!w_last_bit) begin
            r_sreg    <= {r_sreg[WIDTH-2:0], 1'b0};
            r_bit_cnt <= r_bit_cnt + CW'(1);
          end else if (w_hold_valid) begin
            r_sreg    <= w_hold_data;
            r_bit_cnt <= '0;
          end else if (w_accept) begin
            r_sreg    <= bus.p_in;
            r_bit_cnt <= '0;
          end else begin
            r_state     <= IDLE;
            r_sreg      <= '0;
            r_bit_cnt   <= '0;
            r_out_valid <= 1'b0;
          end
        end
        default: begin
          r_state     <= IDLE;
          r_sreg      <= '0;
          r_bit_cnt   <= '0;
          r_out_valid <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready  = !w_hold_valid;
  assign bus.out_valid = r_out_valid;
  assign bus.s_out     = r_sreg[WIDTH-1];

endmodule : piso
`default_nettype wire

// File: tb/tb_piso.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : tb_piso                                                   |
// | Purpose  : Self-checking bench for piso (WIDTH=4). Accepted words    |
// |            go to a scoreboard queue; a serial receiver model         |
// |            rebuilds words from the stream and compares in order.     |
// |            Directed checks cover reset, latency, back-to-back,       |
// |            gaps, last-bit accept and reset mid-word.                 |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module tb_piso;

  localparam int W = 4;

  logic clk;
  logic rst_n;

  piso_if #(.WIDTH(W)) bus ();

  piso #(.WIDTH(W)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  logic [W-1:0] sb[$];     // expected words, in acceptance order
  int           runs[$];   // lengths of completed out_valid bursts
  int           run_len = 0;
  int           rx_cnt  = 0;
  int           rx_words = 0;
  logic [W-1:0] rx_sh   = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Serial receiver model: WIDTH consecutive valid bits, first bit into MSB.
  always @(negedge clk) begin
    if (!rst_n) begin
      rx_cnt  = 0;
      run_len = 0;
    end else if (bus.out_valid) begin
      run_len++;
      rx_sh = {rx_sh[W-2:0], bus.s_out};
      rx_cnt++;
      if (rx_cnt == W) begin
        rx_cnt = 0;
        rx_words++;
        if (sb.size() == 0) chk("sb_underflow", 32'(sb.size()), 32'd1);
        else chk("rx_word", 32'(rx_sh), 32'(sb.pop_front()));
      end
    end else if (run_len > 0) begin
      runs.push_back(run_len);
      run_len = 0;
    end
  end

  // Present a word with in_valid high until accepted; in_valid stays high.
  task automatic send(input logic [W-1:0] w, output int waits);
    logic acc;
    acc   = 1'b0;
    waits = 0;
    bus.in_valid = 1'b1;
    bus.p_in     = w;
    while (!acc && waits < 40) begin
      @(negedge clk);
      acc = bus.in_ready;
      @(posedge clk);
      #1;
      if (!acc) waits++;
    end
    if (acc) sb.push_back(w);
    else chk("accept_timeout", 32'(acc), 32'd1);
  endtask

  task automatic idle(input int n);
    bus.in_valid = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drain();
    int t;
    t = 0;
    bus.in_valid = 1'b0;
    while (sb.size() != 0 && t < 200) begin
      @(posedge clk);
      t++;
    end
    #1;
    chk("drain", 32'(sb.size()), 32'd0);
    idle(3);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int           wt;
    int           w2;
    int           w3;
    int           rx_base;
    logic [W-1:0] word;
    logic [W-1:0] pat;

    // ---- reset, with a word presented during reset (must be ignored)
    rst_n        = 1'b0;
    bus.in_valid = 1'b1;
    bus.p_in     = 4'b1111;
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_s_out",     32'(bus.s_out),     32'd0);
    chk("rst_in_ready",  32'(bus.in_ready),  32'd1);
    rst_n        = 1'b1;
    bus.in_valid = 1'b0;
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("no_accept_in_reset", 32'(bus.out_valid), 32'd0);
    @(posedge clk);
    #1;

    // ---- single word: MSB first, exactly 4 valid cycles
    runs.delete();
    pat = 4'b1011;
    send(pat, wt);
    bus.in_valid = 1'b0;
    for (int i = W - 1; i >= 0; i--) begin
      @(negedge clk);
      chk("single_valid", 32'(bus.out_valid), 32'd1);
      chk("single_bit",   32'(bus.s_out),     32'(pat[i]));
    end
    @(negedge clk);
    chk("single_end_valid", 32'(bus.out_valid), 32'd0);
    chk("single_end_sout",  32'(bus.s_out),     32'd0);
    drain();

    // ---- back-to-back with in_valid held high
    runs.delete();
    send(4'b1011, wt);
    send(4'b0110, w2);
    send(4'b1111, w3);
    chk("b2b_word2_wait", 32'(w2), 32'd0);
    chk("b2b_word3_wait", 32'(w3), 32'd3);
    drain();
    chk("b2b_bursts", 32'(runs.size()), 32'd1);
    if (runs.size() > 0) chk("b2b_len", 32'(runs[0]), 32'd12);

    // ---- gap between two words gives two separate bursts
    runs.delete();
    send(4'b1000, wt);
    idle(6);
    send(4'b0001, wt);
    drain();
    chk("gap_bursts", 32'(runs.size()), 32'd2);
    if (runs.size() == 2) begin
      chk("gap_len0", 32'(runs[0]), 32'd4);
      chk("gap_len1", 32'(runs[1]), 32'd4);
    end

    // ---- accept on the last-bit edge with the holding register empty
    runs.delete();
    send(4'b1100, wt);
    idle(3);
    send(4'b0101, wt);
    chk("lastbit_wait", 32'(wt), 32'd0);
    drain();
    chk("lastbit_bursts", 32'(runs.size()), 32'd1);
    if (runs.size() > 0) chk("lastbit_len", 32'(runs[0]), 32'd8);

    // ---- reset after 2 bits of 1110 with 0011 buffered
    runs.delete();
    send(4'b1110, wt);
    send(4'b0011, wt);
    bus.in_valid = 1'b0;
    chk("midrst_buffered", 32'(bus.in_ready), 32'd0);
    rst_n = 1'b0;
    sb.delete();
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("midrst_valid", 32'(bus.out_valid), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("midrst_ready", 32'(bus.in_ready),  32'd1);
    chk("midrst_idle",  32'(bus.out_valid), 32'd0);
    idle(12);
    chk("midrst_no_burst", 32'(runs.size()), 32'd0);

    // ---- loopback of 16 random words, with occasional gaps
    runs.delete();
    rx_base = rx_words;
    for (int k = 0; k < 16; k++) begin
      word = W'($urandom);
      send(word, wt);
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
    end
    drain();
    chk("loopback_count", 32'(rx_words - rx_base), 32'd16);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule : tb_piso
`default_nettype wire
